// File: rtl/hps_connection_pkg.sv
// Shared types and limits for the hps_connection PIO poller.
// The counter widths are sized for the largest legal parameter values.
package hps_connection_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      LAT,
      GAP
   } poll_state_t;

   localparam int READ_LATENCY_MIN  = 1;
   localparam int READ_LATENCY_MAX  = 7;
   localparam int POLL_INTERVAL_MAX = 65535;

   localparam int LAT_CNT_W = $clog2(READ_LATENCY_MAX + 1);
   localparam int GAP_CNT_W = $clog2(POLL_INTERVAL_MAX + 1);

endpackage

// File: rtl/hps_connection_edge_detect.sv
// Edge detector on the selected captured bit.
// Tracks the previous bit, emits rise/fall pulses and keeps a saturating edge count.
module hps_connection_edge_detect #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             capture,
   input  logic             new_bit,
   input  logic             idle,
   input  logic             count_clr,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] edge_count
);

   logic primed;
   logic prev_bit;
   logic rise_evt;
   logic fall_evt;

   // The first capture after idle only establishes the baseline.
   assign rise_evt = capture & primed & ~prev_bit &  new_bit;
   assign fall_evt = capture & primed &  prev_bit & ~new_bit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         primed     <= 1'b0;
         prev_bit   <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
         edge_count <= '0;
      end else begin
         rise <= rise_evt;
         fall <= fall_evt;
         if (capture) begin
            primed   <= 1'b1;
            prev_bit <= new_bit;
         end else if (idle) begin
            primed <= 1'b0;
         end
         if (count_clr) begin
            edge_count <= '0;
         end else if ((rise_evt | fall_evt) && (edge_count != '1)) begin
            edge_count <= edge_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/hps_connection_pio_poller.sv
// Avalon-MM initiator that periodically reads a PIO data register and reports edges
// on one bit. A read, once issued, is held until accepted and always completes.
module hps_connection_pio_poller
   import hps_connection_pkg::*;
#(
   parameter int ADDR_W        = 2,
   parameter int DATA_W        = 32,
   parameter int POLL_ADDR     = 0,
   parameter int READ_LATENCY  = 1,
   parameter int POLL_INTERVAL = 16,
   parameter int BIT_SEL       = 0,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              count_clr,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [DATA_W-1:0] sample_value,
   output logic              sample_valid,
   output logic              rise,
   output logic              fall,
   output logic [CNT_W-1:0]  edge_count,
   output logic              busy
);

   if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
      $error("READ_LATENCY out of range");
   end
   if (POLL_INTERVAL < 0 || POLL_INTERVAL > POLL_INTERVAL_MAX) begin : g_bad_interval
      $error("POLL_INTERVAL out of range");
   end
   if (BIT_SEL < 0 || BIT_SEL >= DATA_W) begin : g_bad_bit
      $error("BIT_SEL out of range");
   end

   localparam logic [LAT_CNT_W-1:0] LAT_ONE = LAT_CNT_W'(1);
   localparam logic [GAP_CNT_W-1:0] GAP_ONE = GAP_CNT_W'(1);

   poll_state_t          state, state_nxt;
   logic [LAT_CNT_W-1:0] lat_cnt, lat_nxt;
   logic [GAP_CNT_W-1:0] gap_cnt, gap_nxt;
   logic                 capture;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         lat_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_nxt;
         gap_cnt <= gap_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lat_nxt   = lat_cnt;
      gap_nxt   = gap_cnt;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (enable) state_nxt = READ;
         end
         READ: begin
            if (!avm_waitrequest) begin
               state_nxt = LAT;
               lat_nxt   = LAT_CNT_W'(READ_LATENCY);
            end
         end
         LAT: begin
            lat_nxt = lat_cnt - LAT_ONE;
            if (lat_cnt == LAT_ONE) begin
               capture = 1'b1;
               if (POLL_INTERVAL == 0) begin
                  state_nxt = enable ? READ : IDLE;
               end else begin
                  state_nxt = GAP;
                  gap_nxt   = GAP_CNT_W'(POLL_INTERVAL);
               end
            end
         end
         GAP: begin
            gap_nxt = gap_cnt - GAP_ONE;
            if (gap_cnt == GAP_ONE) state_nxt = enable ? READ : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign avm_address = ADDR_W'(POLL_ADDR);
   assign avm_read    = (state == READ);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_value <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= capture;
         if (capture) sample_value <= avm_readdata;
      end
   end

   hps_connection_edge_detect #(
      .CNT_W(CNT_W)
   ) u_edge (
      .clk       (clk),
      .reset_n   (reset_n),
      .capture   (capture),
      .new_bit   (avm_readdata[BIT_SEL]),
      .idle      (state == IDLE),
      .count_clr (count_clr),
      .rise      (rise),
      .fall      (fall),
      .edge_count(edge_count)
   );

endmodule
